// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: FSM state encoding, the queued
// command record, and the timer slave register map (0x000-0x01C).
// Ports: none (package).
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Address is carried at full 32-bit width so one record layout serves any
  // ADDR_W; the master truncates to ADDR_W when driving paddr.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cmd_t;

  // Timer register slave map.
  localparam logic [11:0] TMR_CTRL     = 12'h000;
  localparam logic [11:0] TMR_STATUS   = 12'h004;
  localparam logic [11:0] TMR_LOAD     = 12'h008;
  localparam logic [11:0] TMR_COUNT    = 12'h00C;
  localparam logic [11:0] TMR_CMP0     = 12'h010;
  localparam logic [11:0] TMR_CMP1     = 12'h014;
  localparam logic [11:0] TMR_PRESCALE = 12'h018;
  localparam logic [11:0] TMR_IRQ      = 12'h01C;

  function automatic logic addr_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO of DEPTH entries (power of two) with wrap-around pointers.
// Ports: clk/rst, push+din, pop, dout (head), dout_next (entry behind head),
//        full, empty, multi (two or more entries held).
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_next,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      count;
  logic [AW-1:0]    next_idx;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign multi    = (count > (AW+1)'(1));
  assign next_idx = rptr[AW-1:0] + AW'(1);

  // A push while full is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  assign dout      = mem[rptr[AW-1:0]];
  assign dout_next = mem[next_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: queues valid/ready commands, runs one APB transfer at a time,
// and returns each result through a single-entry response register.
// Ports: clk/rst; cmd_* command stream in; rsp_* response out; p* APB bus.
// Optional APB_CMD_MASTER_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYC wait cycles.
module apb_cmd_master #(
  parameter int ADDR_W      = 12,
  parameter int CMD_DEPTH   = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic              pready,
  input  logic [31:0]       prdata,
  input  logic              pslverr
);

  import apb_cmd_pkg::*;

  apb_state_e state_q;
  apb_state_e state_d;

  cmd_t  cmd_in;
  cmd_t  head;
  cmd_t  head_nxt;
  cmd_t  ld;
  logic  fifo_full;
  logic  fifo_empty;
  logic  fifo_multi;
  logic  push;
  logic  pop;

  logic        slot_free;
  logic        load_apb;
  logic        load_sel;
  logic        cap;
  logic [31:0] cap_rdata;
  logic        cap_err;
  logic        cap_to;
  logic        timeout_hit;
  logic        rsp_to_q;

  // ---------------------------------------------------------------- command FIFO
  assign cmd_in = '{write: cmd_write, addr: 32'(cmd_addr), wdata: cmd_wdata, strb: cmd_strb};
  assign push   = cmd_valid & cmd_ready;
  assign cmd_ready = ~fifo_full;

  apb_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (cmd_in),
    .pop       (pop),
    .dout      (head),
    .dout_next (head_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .multi     (fifo_multi)
  );

  // Upper address bits beyond ADDR_W are carried but never driven onto the bus.
  logic unused_addr;
  assign unused_addr = ^{head.addr, head_nxt.addr};

  // The response slot can take a new result if empty or being drained now.
  assign slot_free = ~rsp_valid | rsp_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_apb  = 1'b0;
    load_sel  = 1'b0;
    cap       = 1'b0;
    cap_rdata = 32'h0;
    cap_err   = 1'b0;
    cap_to    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && slot_free) begin
          if (addr_aligned(head.addr)) begin
            state_d  = ST_SETUP;
            load_apb = 1'b1;
          end else begin
            // Misaligned: retire without touching the bus.
            pop     = 1'b1;
            cap     = 1'b1;
            cap_err = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          pop       = 1'b1;
          cap       = 1'b1;
          cap_err   = pslverr;
          cap_rdata = (pwrite || pslverr) ? 32'h0 : prdata;
          // Chaining straight into SETUP fills the slot with this result, so
          // it is only done while the consumer is accepting responses; the
          // next transfer then cannot complete before this one is drained,
          // provided the consumer keeps rsp_ready up for that transfer.
          if (fifo_multi && addr_aligned(head_nxt.addr) && rsp_ready) begin
            state_d  = ST_SETUP;
            load_apb = 1'b1;
            load_sel = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          pop     = 1'b1;
          cap     = 1'b1;
          cap_err = 1'b1;
          cap_to  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from the state register so both drop with rst asynchronously.
  assign psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable = (state_q == ST_ACCESS);

  // ---------------------------------------------------------------- APB address/data
  // On a chained transfer the head is being popped, so the entry behind it
  // supplies the next bus values.
  assign ld = load_sel ? head_nxt : head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= 32'h0;
      pstrb  <= 4'h0;
    end else if (load_apb) begin
      paddr  <= ld.addr[ADDR_W-1:0];
      pwrite <= ld.write;
      pwdata <= ld.wdata;
      pstrb  <= ld.write ? ld.strb : 4'h0;
    end
  end

  // ---------------------------------------------------------------- response register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      rsp_to_q  <= 1'b0;
    end else if (cap) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= cap_rdata;
      rsp_err   <= cap_err;
      rsp_to_q  <= cap_to;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- ACCESS timeout
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 to_cnt <= '0;
    else if (state_q == ST_SETUP)            to_cnt <= '0;
    else if (state_q == ST_ACCESS && !pready) to_cnt <= to_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYC-th waited ACCESS cycle.
  assign timeout_hit = (state_q == ST_ACCESS) && !pready &&
                       (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign rsp_timeout = rsp_to_q;
`else
  logic unused_to;
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
  assign unused_to   = rsp_to_q ^ (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;

  apb_cmd_master #(.ADDR_W(12), .CMD_DEPTH(2), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues
  typedef struct { logic [31:0] rdata; logic err; logic to; } rsp_exp_t;
  typedef struct { logic [11:0] addr; logic write; logic [31:0] wdata; logic [3:0] strb; } bus_exp_t;
  rsp_exp_t rsp_q[$];
  bus_exp_t bus_q[$];

  // ---------------- slave model + monitors (all on the falling edge)
  int          slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;
  logic        slv_addr_data = 1'b0;
  int acc_seen = 0, acc_cnt = 0, sel_cnt = 0, bus_done = 0;
  int last_done = 0, prev_done = 0, rise_cyc = 0;
  logic rsp_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pready = 1'b0; prdata = 32'h0; pslverr = 1'b0; acc_seen = 0;
    end else begin
      if (psel && penable) begin
        acc_cnt++;
        if (acc_seen >= slv_wait) begin
          pready  = 1'b1;
          prdata  = slv_addr_data ? {20'hABCDE, paddr} : slv_rdata;
          pslverr = slv_err;
        end else begin
          pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        end
        acc_seen++;
      end else begin
        acc_seen = 0; pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
      end
      if (psel) sel_cnt++;
      if (psel && penable && pready) begin
        prev_done = last_done;
        last_done = cyc + 1;
        bus_done++;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_xfer", {20'h0, paddr}, 32'hFFFF_FFFF);
        end else begin
          bus_exp_t b;
          b = bus_q.pop_front();
          chk("paddr", {20'h0, paddr}, {20'h0, b.addr});
          chk("pwrite", {31'h0, pwrite}, {31'h0, b.write});
          chk("pwdata", pwdata, b.wdata);
          chk("pstrb", {28'h0, pstrb}, {28'h0, b.strb});
        end
      end
      if (rsp_valid && !rsp_prev) rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF ^ rsp_rdata ^ 32'h1);
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, r.err});
          chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, r.to});
        end
      end
    end
    rsp_prev = rsp_valid;
  end

  // ---------------- stimulus helpers
  task automatic send(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int acc);
    bit done;
    done = 1'b0;
    acc  = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        acc  = cyc;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL send: command to %h not accepted within 100 cycles", a);
    end
  endtask

  task automatic wait_rsp(input int lim, input string name);
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < lim) begin @(posedge clk); n++; end
    #1;
    if (rsp_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL %s: %0d responses pending after %0d cycles", name, rsp_q.size(), lim);
      rsp_q.delete();
    end
  endtask

  // ---------------- vector table
  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          slv_wait;
    logic [31:0] slv_rdata;
    logic        slv_err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
    int          exp_sel;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, sel0, acc0, bd0, n;

    vecs[0] = '{1'b1, TMR_CTRL,  32'h0000_0103, 4'h3, 0, 32'h0,         1'b0, 32'h0,         1'b0, 4'h3, 2, 3};
    vecs[1] = '{1'b0, TMR_COUNT, 32'h0,         4'h0, 0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'h0, 2, 3};
    vecs[2] = '{1'b1, TMR_CTRL,  32'h0000_0900, 4'h2, 0, 32'h0,         1'b1, 32'h0,         1'b1, 4'h2, 2, 3};
    vecs[3] = '{1'b0, 12'h006,   32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 4'h0, 0, 1};
    vecs[4] = '{1'b0, TMR_LOAD,  32'h0,         4'hF, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 4'h0, 4, 5};
    vecs[5] = '{1'b0, TMR_CMP0,  32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b1, 32'h0,         1'b1, 4'h0, 2, 3};
    vecs[6] = '{1'b1, TMR_IRQ,   32'hA5A5_A5A5, 4'hF, 1, 32'h0,         1'b0, 32'h0,         1'b0, 4'hF, 3, 4};
    vecs[7] = '{1'b1, 12'h003,   32'h0000_0077, 4'hF, 0, 32'h0,         1'b0, 32'h0,         1'b1, 4'h0, 0, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
    chk("reset_psel_penable", {30'h0, psel, penable}, 32'h0);
    chk("reset_paddr_pwrite", {19'h0, paddr, pwrite}, 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    chk("reset_pstrb", {28'h0, pstrb}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- table-driven single commands
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_wait = vecs[i].slv_wait; slv_rdata = vecs[i].slv_rdata; slv_err = vecs[i].slv_err;
      rsp_q.push_back('{rdata: vecs[i].exp_rdata, err: vecs[i].exp_err, to: 1'b0});
      if (vecs[i].exp_sel != 0)
        bus_q.push_back('{addr: vecs[i].addr, write: vecs[i].write,
                          wdata: vecs[i].wdata, strb: vecs[i].exp_pstrb});
      sel0 = sel_cnt;
      send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb, acc);
      wait_rsp(50, $sformatf("vec%0d_rsp", i));
      chk($sformatf("vec%0d_latency", i), rise_cyc - acc, vecs[i].exp_lat);
      chk($sformatf("vec%0d_psel_cycles", i), sel_cnt - sel0, vecs[i].exp_sel);
      chk($sformatf("vec%0d_bus_drained", i), bus_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
    end

    // ---- back-to-back writes: 2-cycle issue interval
    slv_wait = 0; slv_err = 1'b0; slv_addr_data = 1'b1;
    rsp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    rsp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    bus_q.push_back('{addr: TMR_CMP0, write: 1'b1, wdata: 32'h11, strb: 4'h1});
    bus_q.push_back('{addr: TMR_CMP1, write: 1'b1, wdata: 32'h22, strb: 4'hC});
    bd0 = bus_done;
    send(1'b1, TMR_CMP0, 32'h11, 4'h1, acc);
    send(1'b1, TMR_CMP1, 32'h22, 4'hC, acc);
    wait_rsp(50, "b2b_rsp");
    chk("b2b_xfers", bus_done - bd0, 2);
    chk("b2b_issue_interval", last_done - prev_done, 2);
    repeat (2) @(posedge clk);
    #1;

    // ---- backpressure: depth-2 FIFO, response held
    rsp_ready = 1'b0;
    rsp_q.push_back('{rdata: 32'hABCD_E004, err: 1'b0, to: 1'b0});
    rsp_q.push_back('{rdata: 32'hABCD_E008, err: 1'b0, to: 1'b0});
    rsp_q.push_back('{rdata: 32'hABCD_E018, err: 1'b0, to: 1'b0});
    bus_q.push_back('{addr: TMR_STATUS,   write: 1'b0, wdata: 32'h0, strb: 4'h0});
    bus_q.push_back('{addr: TMR_LOAD,     write: 1'b0, wdata: 32'h0, strb: 4'h0});
    bus_q.push_back('{addr: TMR_PRESCALE, write: 1'b0, wdata: 32'h0, strb: 4'h0});
    bd0 = bus_done;
    send(1'b0, TMR_STATUS, 32'h0, 4'h0, acc);
    send(1'b0, TMR_LOAD, 32'h0, 4'h0, acc);
    @(negedge clk);
    chk("bp_cmd_ready_full", {31'h0, cmd_ready}, 32'h0);
    send(1'b0, TMR_PRESCALE, 32'h0, 4'h0, acc);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_one_xfer", bus_done - bd0, 1);
    chk("bp_rsp_held", {31'h0, rsp_valid}, 32'h1);
    chk("bp_no_psel", {31'h0, psel}, 32'h0);
    rsp_ready = 1'b1;
    wait_rsp(60, "bp_rsp");
    chk("bp_all_xfers", bus_done - bd0, 3);
    slv_addr_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // ---- ACCESS timeout
    slv_wait = 100000;
    rsp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
    acc0 = acc_cnt;
    send(1'b0, TMR_STATUS, 32'h0, 4'h0, acc);
    wait_rsp(400, "timeout_rsp");
    chk("timeout_access_cycles", acc_cnt - acc0, 256);
    chk("timeout_psel_low", {31'h0, psel}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
`endif

    // ---- reset during ACCESS
    slv_wait = 1000;
    bd0 = bus_done;
    send(1'b1, TMR_LOAD, 32'h55, 4'hF, acc);
    n = 0;
    while (!(psel && penable) && n < 20) begin @(negedge clk); n++; end
    chk("rst_reached_access", {31'h0, psel && penable}, 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_psel_penable", {30'h0, psel, penable}, 32'h0);
    chk("rst_async_paddr_pwrite", {19'h0, paddr, pwrite}, 32'h0);
    chk("rst_async_pstrb_pwdata", {pwdata[27:0], pstrb}, 32'h0);
    chk("rst_async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_async_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_rsp_after", {31'h0, rsp_valid}, 32'h0);
    chk("rst_fifo_discarded", {31'h0, psel}, 32'h0);
    chk("rst_no_xfer", bus_done - bd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master
APB4 requester that turns a simple valid/ready command stream into APB transfers toward the timer register slave and returns each result as a buffered response. It sits between a CPU/testbench-side command source and the timer's APB port, with `CMD_DEPTH` outstanding commands queued and exactly one APB transfer in flight.
## Interface
- `ADDR_W`, 12: APB address width; the timer map occupies 0x000–0x01C.
- `CMD_DEPTH`, 2: command FIFO entries; a power of two, at least 2.
- `TIMEOUT_CYC`, 256: ACCESS-phase wait limit in cycles; used only with the timeout feature.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  `ADDR_W`  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_strb`  in  4  byte strobes, used on writes only.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  the consumer takes the response when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  32  read data; 0 for writes and for errors.
- `rsp_err`  out  1  `pslverr` was seen, the address was misaligned, or the transfer timed out.
- `rsp_timeout`  out  1  the error was a timeout; constant 0 without the macro.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB write.
- `paddr`  out  `ADDR_W`  APB address.
- `pwdata`  out  32  APB write data.
- `pstrb`  out  4  APB strobes; forced to 0 on reads.
- `pready`  in  1  slave ready.
- `prdata`  in  32  slave read data.
- `pslverr`  in  1  slave error; sampled only when `pready` is high in ACCESS.
## Operation
- Reset state of all outputs: `cmd_ready`=1. Every other output, including the response register and all APB outputs, is 0. The FIFO is empty.
- The FSM has three states: IDLE, SETUP, ACCESS.
- IDLE → SETUP when the FIFO is non-empty, the head address is aligned, and the response slot is free. The slot is free when `rsp_valid` is 0, or when `rsp_valid & rsp_ready` in the same cycle.
- SETUP (`psel`=1, `penable`=0) → ACCESS unconditionally after one cycle.
- ACCESS (`psel`=1, `penable`=1) → completes on `pready`=1:
  - Capture `prdata` (reads only) and `pslverr` into the response register, then pop the FIFO.
  - If the next command is eligible, go directly to SETUP; otherwise go to IDLE with `psel`=0.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are registered at IDLE/ACCESS→SETUP. They hold stable through ACCESS and keep their values after the transfer ends. `pstrb` is 0 on reads.
- Misaligned head (`cmd_addr[1:0]`≠0): no bus cycle is issued. The command is popped with `rsp_err`=1 and `rsp_rdata`=0 once the response slot is free.
- Responses come out in command order. At most one response is buffered; while the slot is full and not draining, no new SETUP is started.
- A FIFO push and pop in the same cycle while full is allowed; the occupancy is unchanged.
## Timing
- Command accepted at edge N with the FIFO previously empty and the FSM in IDLE: SETUP in cycle N+1, ACCESS in N+2.
- Zero-wait slave: `rsp_valid` rises at edge N+3, so the latency is 3 cycles.
- Each wait state (`pready`=0) adds one cycle.
- Back-to-back transfers: the next SETUP immediately follows the completing ACCESS cycle, giving a 2-cycle issue interval.
- Reset mid-transfer: `psel`/`penable` drop asynchronously. The FIFO and the response are discarded, and the slave sees an aborted transfer.
## Configuration
- `APB_CMD_MASTER_TIMEOUT_EN` defined: a counter runs in ACCESS while `pready`=0.
  - When it reaches `TIMEOUT_CYC`, the transfer ends: next state IDLE, `psel`=0.
  - The response is `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - The counter clears on every SETUP.
- Macro undefined: ACCESS waits for `pready` indefinitely, and `rsp_timeout` is tied to 0.
## Structure
- Shared package `apb_cmd_pkg` holds:
  - the FSM state enum;
  - the command struct {write, addr, wdata, strb};
  - the timer register address constants 0x000–0x01C.
- One sub-module, `apb_cmd_fifo`: synchronous FIFO of `CMD_DEPTH` entries with full/empty flags and wrap-around pointers.
## Test plan
- Write 0x000 with wdata 0x0000_0103 and strb 0x3, zero-wait slave → SETUP then ACCESS; `pstrb`=0x3; `rsp_valid` 3 cycles after accept; `rsp_err`=0.
- Read 0x00C after reset → `pstrb`=0; `rsp_rdata`=0xFFFF_FFFF; `rsp_err`=0.
- Write 0x000 with wdata 0x0000_0900 and strb 0x2 → slave asserts `pslverr`; response has `rsp_err`=1 and `rsp_timeout`=0.
- Push 3 commands with `CMD_DEPTH`=2 and `rsp_ready`=0 → `cmd_ready` falls after 2 accepted; only one bus transfer completes until `rsp_ready` rises; responses arrive in order.
- Read at 0x006 → no `psel` pulse; `rsp_err`=1.
- With the timeout macro, hold `pready`=0 → `psel` drops after `TIMEOUT_CYC` (256) ACCESS cycles; `rsp_timeout`=1. Assert `rst` during ACCESS → all outputs return to 0 asynchronously.
